// File: rtl/div_stall_unit.sv
// div_stall_unit: multi-cycle restoring divider for the EX stage.
// It requests a pipeline stall while a DIV/DIVU occupies EX. It releases the
// stall in the cycle where the quotient (LO) and remainder (HI) are presented.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting; a start without annul latches the operands
//   CALC   | one restoring-division iteration per cycle (WIDTH cycles)
//   DONE   | sign-corrected result valid, ready pulses, stall released
module div_stall_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_startE,
  input  logic             div_signedE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             annulE,
  output logic             div_stallE,
  output logic             div_readyE,
  output logic [WIDTH-1:0] hiE,
  output logic [WIDTH-1:0] loE
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvsr_q, dvnd_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             neg_quo_q, neg_rem_q, dvsr_zero_q;

  logic             last_iter;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   shifted, trial;
  logic             borrow;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic [WIDTH-1:0] lo_fix, hi_fix;

  assign last_iter = (state_q == S_CALC) && (cnt_q == CNT_W'(WIDTH - 1));

  // Operand magnitudes; the sign is only stripped for signed DIV.
  always_comb begin
    abs_a = srcaE;
    abs_b = srcbE;
    if (div_signedE && srcaE[WIDTH-1]) abs_a = -srcaE;
    if (div_signedE && srcbE[WIDTH-1]) abs_b = -srcbE;
  end

  // One restoring step. The partial remainder is always below the divisor, so
  // the shifted value fits WIDTH+1 bits and the top bit of the trial result is
  // the borrow.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr_q};
    borrow  = trial[WIDTH];
    rem_nxt = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_nxt = {quo_q[WIDTH-2:0], ~borrow};
  end

  // Final sign correction; a zero divisor bypasses it and returns the raw dividend.
  always_comb begin
    lo_fix = neg_quo_q ? -quo_nxt : quo_nxt;
    hi_fix = neg_rem_q ? -rem_nxt : rem_nxt;
    if (dvsr_zero_q) begin
      lo_fix = '1;
      hi_fix = dvnd_q;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; annul wins from every state.
  always_comb begin
    state_d = state_q;
    if (annulE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (div_startE) state_d = S_CALC;
        S_CALC:  if (last_iter)  state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath: operand capture, iteration, and the result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      dvnd_q      <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dvsr_zero_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else if (annulE) begin
      cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (div_startE) begin
            rem_q       <= '0;
            quo_q       <= abs_a;
            dvsr_q      <= abs_b;
            dvnd_q      <= srcaE;
            neg_quo_q   <= div_signedE & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
            neg_rem_q   <= div_signedE & srcaE[WIDTH-1];
            dvsr_zero_q <= (srcbE == '0);
            cnt_q       <= '0;
          end
        end
        S_CALC: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q + 1'b1;
          if (last_iter) begin
            hi_q <= hi_fix;
            lo_q <= lo_fix;
          end
        end
        default: begin
          cnt_q <= '0;
        end
      endcase
    end
  end

  // The result is presented for one cycle. The stall is released in that same cycle.
  always_comb begin
    div_readyE = (state_q == S_DONE) && !annulE;
    div_stallE = div_startE & ~div_readyE & ~annulE;
    hiE        = hi_q;
    loE        = lo_q;
  end

endmodule

// File: tb/tb_div_stall_unit.sv
// Directed and randomized bench for div_stall_unit. A plain-arithmetic
// reference computes the expected DIV/DIVU results.
module tb_div_stall_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        div_startE = 1'b0;
  logic        div_signedE = 1'b0;
  logic [31:0] srcaE = '0;
  logic [31:0] srcbE = '0;
  logic        annulE = 1'b0;
  logic        div_stallE, div_readyE;
  logic [31:0] hiE, loE;

  int compared = 0;
  int mismatched = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  div_stall_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .div_startE(div_startE), .div_signedE(div_signedE),
    .srcaE(srcaE), .srcbE(srcbE), .annulE(annulE), .div_stallE(div_stallE),
    .div_readyE(div_readyE), .hiE(hiE), .loE(loE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic [31:0] r);
    int sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (s) begin
      sa = a;
      sb = b;
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Issue one divide, hold start until ready, then check latency and results.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] eq, er;
    int cycles;
    ref_div(a, b, s, eq, er);
    if (div_readyE) @(negedge clk);
    div_startE = 1'b1; div_signedE = s; srcaE = a; srcbE = b; annulE = 1'b0;
    #1;
    cycles = 0;
    while (div_readyE !== 1'b1 && cycles < 100) begin
      chk("stall_hold", {31'd0, div_stallE}, 32'd1);
      cycles++;
      @(negedge clk);
      srcaE = $urandom; srcbE = $urandom; div_signedE = 1'($urandom_range(0, 1));
      #1;
    end
    chk("latency", cycles, 32'd33);
    chk("stall_in_done", {31'd0, div_stallE}, 32'd0);
    chk("lo", loE, eq);
    chk("hi", hiE, er);
    last_lo = eq;
    last_hi = er;
  endtask

  // Drop start and check that the result holds with no further ready pulse.
  task automatic end_div();
    div_startE = 1'b0;
    @(negedge clk);
    #1;
    chk("ready_after", {31'd0, div_readyE}, 32'd0);
    chk("stall_idle", {31'd0, div_stallE}, 32'd0);
    chk("lo_hold", loE, last_lo);
    chk("hi_hold", hiE, last_hi);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    #1;
    chk("rst_hi", hiE, 32'd0);
    chk("rst_lo", loE, 32'd0);
    chk("rst_ready", {31'd0, div_readyE}, 32'd0);
    chk("rst_stall", {31'd0, div_stallE}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_div(32'd100, 32'd7, 1'b0);                end_div();
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1);          end_div();
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1);          end_div();
    run_div(32'h1234_5678, 32'd0, 1'b0);          end_div();
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);  end_div();
    run_div(32'hFFFF_FFF9, 32'd0, 1'b1);          end_div();

    // Annul at the tenth CALC cycle.
    div_startE = 1'b1; div_signedE = 1'b0; srcaE = 32'd50; srcbE = 32'd5;
    repeat (10) @(negedge clk);
    #1 annulE = 1'b1;
    #1;
    chk("annul_stall", {31'd0, div_stallE}, 32'd0);
    chk("annul_ready", {31'd0, div_readyE}, 32'd0);
    chk("annul_lo", loE, last_lo);
    chk("annul_hi", hiE, last_hi);
    @(negedge clk);
    annulE = 1'b0; div_startE = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    chk("annul_no_ready", {31'd0, div_readyE}, 32'd0);
    chk("annul_lo_hold", loE, last_lo);
    chk("annul_hi_hold", hiE, last_hi);
    run_div(32'd9, 32'd4, 1'b0);                  end_div();

    // Back-to-back divides.
    run_div(32'd20, 32'd3, 1'b0);
    run_div(32'd20, 32'd6, 1'b0);
    end_div();

    // Asynchronous reset during CALC.
    div_startE = 1'b1; div_signedE = 1'b0; srcaE = 32'd1000; srcbE = 32'd3;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hi", hiE, 32'd0);
    chk("arst_lo", loE, 32'd0);
    chk("arst_ready", {31'd0, div_readyE}, 32'd0);
    last_hi = '0;
    last_lo = '0;
    div_startE = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_stall", {31'd0, div_stallE}, 32'd0);
    run_div(32'd1000, 32'd3, 1'b0);               end_div();

    // Randomized divides, sometimes back-to-back.
    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = $urandom;
        default: rb = -32'($urandom_range(1, 15));
      endcase
      run_div(ra, rb, rs);
      if ($urandom_range(0, 1) == 0) end_div();
    end
    end_div();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
